// File: rtl/dit_miter_monitor.sv
// Timing-divergence monitor for a DIT miter: per-channel timestamp FIFOs for copies A/B, sticky divergence flags.
// Optional DIT_READY_CHECK_EN adds ready_a/ready_b ports, per-copy push gating and ready divergence.
module dit_ts_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [CNT_W-1:0] ts,
  input  logic             push,
  input  logic             pop,
  output logic [CNT_W-1:0] lat,
  output logic             err
);
  localparam int AW = $clog2(DEPTH);

  logic [CNT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr, rd;
  logic [AW:0]      cnt;
  logic             empty, full, do_pop, do_push;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when its head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr] <= ts;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr  <= '0;
      rd  <= '0;
      cnt <= '0;
      lat <= '0;
      err <= 1'b0;
    end else if (clear) begin
      wr  <= '0;
      rd  <= '0;
      cnt <= '0;
      lat <= '0;
      err <= 1'b0;
    end else begin
      if (do_push) wr <= wr + AW'(1);
      if (do_pop) begin
        rd  <= rd + AW'(1);
        lat <= ts - mem[rd];
      end
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      if ((push & full & ~do_pop) | (pop & empty)) err <= 1'b1;
    end
  end
endmodule

module dit_miter_monitor #(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8,
  parameter int CYC_W  = 32,
  localparam int FCH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic [NUM_CH-1:0]       req_valid,
  input  logic [NUM_CH-1:0]       resp_valid_a,
  input  logic [NUM_CH-1:0]       resp_valid_b,
`ifdef DIT_READY_CHECK_EN
  input  logic [NUM_CH-1:0]       ready_a,
  input  logic [NUM_CH-1:0]       ready_b,
`endif
  output logic [NUM_CH-1:0]       mismatch,
  output logic                    mismatch_any,
  output logic [NUM_CH-1:0]       proto_err,
  output logic [FCH_W-1:0]        first_ch,
  output logic [CYC_W-1:0]        first_cycle,
  output logic [NUM_CH*CNT_W-1:0] lat_a,
  output logic [NUM_CH*CNT_W-1:0] lat_b
);
  logic [CYC_W-1:0]  cyc;
  logic [CNT_W-1:0]  ts;
  logic [NUM_CH-1:0] push_a, push_b, div, err_a, err_b;
  logic [FCH_W-1:0]  fch_nxt;
  logic              found;

`ifdef DIT_READY_CHECK_EN
  assign push_a = req_valid & ready_a;
  assign push_b = req_valid & ready_b;
  assign div    = (resp_valid_a ^ resp_valid_b) | (ready_a ^ ready_b);
`else
  assign push_a = req_valid;
  assign push_b = req_valid;
  assign div    = resp_valid_a ^ resp_valid_b;
`endif

  assign ts           = cyc[CNT_W-1:0];
  assign mismatch_any = |mismatch;
  assign proto_err    = err_a | err_b;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    dit_ts_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo_a (
      .clk(clk), .rst_n(rst_n), .clear(clear), .ts(ts),
      .push(push_a[c]), .pop(resp_valid_a[c]),
      .lat(lat_a[c*CNT_W +: CNT_W]), .err(err_a[c])
    );
    dit_ts_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo_b (
      .clk(clk), .rst_n(rst_n), .clear(clear), .ts(ts),
      .push(push_b[c]), .pop(resp_valid_b[c]),
      .lat(lat_b[c*CNT_W +: CNT_W]), .err(err_b[c])
    );
  end

  // Descending scan so the lowest diverging channel wins.
  always_comb begin
    fch_nxt = '0;
    for (int c = NUM_CH-1; c >= 0; c--)
      if (div[c]) fch_nxt = FCH_W'(c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc         <= '0;
      mismatch    <= '0;
      found       <= 1'b0;
      first_ch    <= '0;
      first_cycle <= '0;
    end else if (clear) begin
      cyc         <= '0;
      mismatch    <= '0;
      found       <= 1'b0;
      first_ch    <= '0;
      first_cycle <= '0;
    end else begin
      cyc      <= cyc + CYC_W'(1);
      mismatch <= mismatch | div;
      if (!found && |div) begin
        found       <= 1'b1;
        first_ch    <= fch_nxt;
        first_cycle <= cyc;
      end
    end
  end
endmodule

// File: tb/tb_dit_miter_monitor.sv
// Randomized bench for dit_miter_monitor against a queue-based reference model (NUM_CH=2, DEPTH=4).
module tb_dit_miter_monitor;
  localparam int NC = 2, DP = 4, CW = 8, YW = 32;

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic [NC-1:0] req_valid = '0, resp_valid_a = '0, resp_valid_b = '0;
  logic [NC-1:0] ready_a = '1, ready_b = '1;
  logic [NC-1:0] mismatch, proto_err;
  logic          mismatch_any;
  logic          first_ch;
  logic [YW-1:0] first_cycle;
  logic [NC*CW-1:0] lat_a, lat_b;

  dit_miter_monitor #(.NUM_CH(NC), .DEPTH(DP), .CNT_W(CW), .CYC_W(YW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .req_valid(req_valid), .resp_valid_a(resp_valid_a), .resp_valid_b(resp_valid_b),
`ifdef DIT_READY_CHECK_EN
    .ready_a(ready_a), .ready_b(ready_b),
`endif
    .mismatch(mismatch), .mismatch_any(mismatch_any), .proto_err(proto_err),
    .first_ch(first_ch), .first_cycle(first_cycle), .lat_a(lat_a), .lat_b(lat_b)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: timestamps kept as full cycle numbers, latency taken mod 2^CW.
  int unsigned qa[NC][$], qb[NC][$];
  bit [CW-1:0] m_lat_a[NC], m_lat_b[NC];
  bit [NC-1:0] m_mis, m_perr;
  bit          m_found, m_fch;
  int unsigned m_fcyc, m_cyc;

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      qa[c].delete(); qb[c].delete();
      m_lat_a[c] = '0; m_lat_b[c] = '0;
    end
    m_mis = '0; m_perr = '0; m_found = 0; m_fch = 0; m_fcyc = 0; m_cyc = 0;
  endtask

  task automatic model_edge();
    bit [NC-1:0] dv, pa, pb;
    if (clear) begin
      model_reset();
      return;
    end
    dv = resp_valid_a ^ resp_valid_b;
    pa = req_valid;
    pb = req_valid;
`ifdef DIT_READY_CHECK_EN
    dv = dv | (ready_a ^ ready_b);
    pa = req_valid & ready_a;
    pb = req_valid & ready_b;
`endif
    for (int c = 0; c < NC; c++) begin
      if (resp_valid_a[c]) begin
        if (qa[c].size() == 0) m_perr[c] = 1;
        else m_lat_a[c] = CW'(m_cyc - qa[c].pop_front());
      end
      if (pa[c]) begin
        if (qa[c].size() >= DP) m_perr[c] = 1;
        else qa[c].push_back(m_cyc);
      end
      if (resp_valid_b[c]) begin
        if (qb[c].size() == 0) m_perr[c] = 1;
        else m_lat_b[c] = CW'(m_cyc - qb[c].pop_front());
      end
      if (pb[c]) begin
        if (qb[c].size() >= DP) m_perr[c] = 1;
        else qb[c].push_back(m_cyc);
      end
    end
    m_mis = m_mis | dv;
    if (!m_found && dv != 0) begin
      m_found = 1;
      m_fcyc  = m_cyc;
      m_fch   = dv[0] ? 1'b0 : 1'b1;
    end
    m_cyc++;
  endtask

  task automatic check_all();
    chk("mismatch", 64'(mismatch), 64'(m_mis));
    chk("mismatch_any", 64'(mismatch_any), 64'(|m_mis));
    chk("proto_err", 64'(proto_err), 64'(m_perr));
    chk("first_ch", 64'(first_ch), 64'(m_fch));
    chk("first_cycle", 64'(first_cycle), 64'(m_fcyc));
    chk("lat_a", 64'(lat_a), 64'({m_lat_a[1], m_lat_a[0]}));
    chk("lat_b", 64'(lat_b), 64'({m_lat_b[1], m_lat_b[0]}));
  endtask

  task automatic step(input logic [1:0] rq, input logic [1:0] ra, input logic [1:0] rb,
                      input logic clr);
    req_valid = rq; resp_valid_a = ra; resp_valid_b = rb; clear = clr;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 2'b00, 2'b00, 1'b0);
  endtask

  initial begin
    model_reset();
    #12;
    chk("reset_mismatch", 64'(mismatch), 64'd0);
    chk("reset_lat_a", 64'(lat_a), 64'd0);
    chk("reset_first_cycle", 64'(first_cycle), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency and single-channel divergence scenario, starting at cyc 0.
    idle(2);                                 // cyc 0,1
    step(2'b10, 2'b00, 2'b00, 1'b0);         // cyc 2: req ch1
    step(2'b01, 2'b00, 2'b00, 1'b0);         // cyc 3: req ch0
    idle(1);                                 // cyc 4
    step(2'b00, 2'b10, 2'b00, 1'b0);         // cyc 5: A responds ch1
    step(2'b00, 2'b00, 2'b10, 1'b0);         // cyc 6: B responds ch1
    step(2'b00, 2'b01, 2'b01, 1'b0);         // cyc 7: both respond ch0
    chk("tp_lat_a0", 64'(lat_a[7:0]), 64'd4);
    chk("tp_lat_b0", 64'(lat_b[7:0]), 64'd4);
    chk("tp_lat_a1", 64'(lat_a[15:8]), 64'd3);
    chk("tp_lat_b1", 64'(lat_b[15:8]), 64'd4);
    chk("tp_mismatch", 64'(mismatch), 64'd2);
    chk("tp_first_ch", 64'(first_ch), 64'd1);
    chk("tp_first_cycle", 64'(first_cycle), 64'd5);
    chk("tp_proto_err", 64'(proto_err), 64'd0);

    // Simultaneous divergence on both channels at cyc 10, later one at cyc 20.
    step(2'b00, 2'b00, 2'b00, 1'b1);
    idle(10);
    step(2'b11, 2'b01, 2'b10, 1'b0);
    chk("both_first_ch", 64'(first_ch), 64'd0);
    chk("both_first_cycle", 64'(first_cycle), 64'd10);
    idle(9);
    step(2'b00, 2'b10, 2'b00, 1'b0);
    chk("late_first_cycle", 64'(first_cycle), 64'd10);
    step(2'b00, 2'b00, 2'b00, 1'b1);
    chk("clear_mismatch", 64'(mismatch), 64'd0);
    chk("clear_proto_err", 64'(proto_err), 64'd0);

    // Overflow: 5 pushes, then 4 good pops and one underflow.
    for (int i = 0; i < 5; i++) step(2'b01, 2'b00, 2'b00, 1'b0);
    chk("ovf_proto_err", 64'(proto_err), 64'd1);
    for (int i = 0; i < 5; i++) step(2'b00, 2'b01, 2'b01, 1'b0);
    chk("ovf_lat_a0", 64'(lat_a[7:0]), 64'd5);
    step(2'b00, 2'b00, 2'b00, 1'b1);

    // Full with simultaneous push and pop is legal.
    for (int i = 0; i < 4; i++) step(2'b01, 2'b00, 2'b00, 1'b0);
    idle(2);
    step(2'b01, 2'b01, 2'b01, 1'b0);
    chk("full_pp_proto_err", 64'(proto_err), 64'd0);
    chk("full_pp_lat", 64'(lat_a[7:0]), 64'd6);
    step(2'b00, 2'b01, 2'b01, 1'b0);
    step(2'b00, 2'b01, 2'b01, 1'b0);
    step(2'b00, 2'b01, 2'b01, 1'b0);
    step(2'b00, 2'b01, 2'b01, 1'b0);
    chk("full_pp_drained", 64'(proto_err), 64'd0);
    step(2'b00, 2'b00, 2'b00, 1'b1);

    // Randomized traffic: mostly lockstep responses with rare divergence and clears.
    for (int i = 0; i < 1500; i++) begin
      logic [1:0] rq, ra, rb;
      logic clr;
      rq = 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3));
      ra = 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3));
      rb = ra;
      if ($urandom_range(0, 40) == 0) rb = rb ^ 2'($urandom_range(1, 3));
      clr = ($urandom_range(0, 90) == 0);
      ready_a = '1;
      ready_b = '1;
      if ($urandom_range(0, 8) == 0) ready_a = 2'($urandom_range(0, 3));
      ready_b = ready_a;
      if ($urandom_range(0, 60) == 0) ready_b = ready_b ^ 2'($urandom_range(1, 3));
      step(rq, ra, rb, clr);
      if (i == 700) begin
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/dit_miter_monitor.md
# dit_miter_monitor

Parametrised timing-divergence monitor for data-independent-timing (DIT) miters. It sits beside two instances of the same functional unit, A and B, which receive identical control and differing secret data. Per channel, it tracks requests shared by both copies and the response handshakes of each copy. It flags, stickily, any cycle in which A's and B's response timing diverges, and records per-copy latency plus the first divergence for formal and simulation debug.

## Interface
- NUM_CH, 2, number of independent request/response channels (≥1)
- DEPTH, 4, max outstanding requests tracked per channel per copy (power of 2, ≥2)
- CNT_W, 8, latency counter/timestamp width
- CYC_W, 32, free-running cycle counter width
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- clear  in  1  synchronous clear of all state (flags, FIFOs, counters)
- req_valid  in  NUM_CH  request issued to both copies on channel c
- resp_valid_a  in  NUM_CH  copy A response handshake on channel c
- resp_valid_b  in  NUM_CH  copy B response handshake on channel c
- ready_a  in  NUM_CH  copy A request-ready (present only with DIT_READY_CHECK_EN)
- ready_b  in  NUM_CH  copy B request-ready (present only with DIT_READY_CHECK_EN)
- mismatch  out  NUM_CH  sticky per-channel divergence flag
- mismatch_any  out  1  OR of mismatch
- proto_err  out  NUM_CH  sticky per-channel protocol error (FIFO over/underflow)
- first_ch  out  max(1,$clog2(NUM_CH))  channel of first divergence
- first_cycle  out  CYC_W  cycle count at first divergence
- lat_a  out  NUM_CH*CNT_W  last measured A latency per channel, channel c at [c*CNT_W +: CNT_W]
- lat_b  out  NUM_CH*CNT_W  same for copy B

## Operation
- Cycle counter `cyc` increments every cycle and wraps mod 2^CYC_W. Timestamp = cyc[CNT_W-1:0].
- Per channel, per copy: a DEPTH-entry timestamp FIFO with an occupancy count of 0..DEPTH.
- Push: when req_valid[c] is high, the current timestamp is written to both A and B FIFOs. With DIT_READY_CHECK_EN, copy x is pushed only when req_valid[c] && ready_x[c].
- Pop x: when resp_valid_x[c] is high and the FIFO is non-empty, lat_x[c] is loaded with (timestamp − head) mod 2^CNT_W. Latencies ≥ 2^CNT_W alias; this is accepted.
- Divergence on channel c: resp_valid_a[c] != resp_valid_b[c] in any cycle. With DIT_READY_CHECK_EN, ready_a[c] != ready_b[c] is also a divergence.
- Divergence sets mismatch[c]. On the first divergence since reset/clear, first_cycle is loaded with cyc, and first_ch with the lowest-index diverging channel if several diverge in the same cycle. Both hold until reset/clear.
- Protocol error sets proto_err[c]:
  - Push while full: no push, count unchanged.
  - Pop while empty: no pop, lat unchanged, even if a push happens in the same cycle (zero-latency responses are illegal).
- Full with simultaneous push and pop: legal. Head is popped, new entry written, count unchanged.
- Each copy's error handling is independent. A's and B's FIFOs may hold different occupancies after a divergence.
- clear: all state returns to reset values next edge. Events in the clear cycle are discarded.

## Timing
- Reset values: mismatch=0, mismatch_any=0, proto_err=0, first_ch=0, first_cycle=0, lat_a=0, lat_b=0, cyc=0, all FIFOs empty.
- All flag and latency outputs are registered. Each updates one cycle after the sampling edge of the causing inputs.
- mismatch_any is combinational from registered mismatch (no extra latency).
- Asserting reset mid-operation clears everything immediately. Deassertion is synchronized by the integrator. The first cycle after release counts as cyc=0.
- Flags are sticky: they are never cleared by later matching behaviour.

## Configuration
- DIT_READY_CHECK_EN defined: ready_a/ready_b ports exist. Ready divergence counts as mismatch, and pushes are gated per copy by ready.
- Undefined: ready ports are absent. Pushes depend only on req_valid, and only response timing is compared.

## Test plan
- NUM_CH=2: req_valid[0] at cyc 3, both resp_valid[0] at cyc 7 -> lat_a[0]=lat_b[0]=4, mismatch=0, proto_err=0.
- req_valid[1] at cyc 2, resp_valid_a[1] at cyc 5, resp_valid_b[1] at cyc 6 -> mismatch=2'b10 from cyc 6, first_ch=1, first_cycle=5, lat_a[1]=3, lat_b[1]=4.
- Divergence on both channels at cyc 10 -> first_ch=0, first_cycle=10. Later divergence at cyc 20 leaves both unchanged. clear -> all flags 0.
- DEPTH=4: 5 back-to-back requests with no responses -> proto_err[c]=1 at the 5th push, occupancy 4. Then 4 pops succeed, a 5th pop sets no new state.
- Fill to full, then push and pop in the same cycle -> no proto_err, occupancy stays 4, lat equals the head-entry age.
- With DIT_READY_CHECK_EN: ready_a[0]=1, ready_b[0]=0 at cyc 4 -> mismatch[0]=1, first_cycle=4. Only A's FIFO is pushed if req_valid[0]=1.
